// File: rtl/adc_host_bridge.sv
// Host register-bus bridge for the ADC digital core: holds the two configuration words,
// queues conversion results in a FIFO and exposes config/status/results to the host.
module adc_host_bridge #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter logic [15:0] CONFIG1_RESET = 16'h0000,
  parameter logic [15:0] CONFIG2_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] config_1_out,
  output logic [15:0] config_2_out,
  input  logic [15:0] result_in,
  input  logic        conv_finished_in,
  input  logic [1:0]  bus_addr_in,
  input  logic [15:0] bus_wdata_in,
  input  logic        bus_we_in,
  input  logic        bus_re_in,
  output logic [15:0] bus_rdata_out,
  output logic        bus_rvalid_out,
  output logic        fifo_nempty_out
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  localparam logic [1:0] AddrCfg1   = 2'd0;
  localparam logic [1:0] AddrCfg2   = 2'd1;
  localparam logic [1:0] AddrStatus = 2'd2;
  localparam logic [1:0] AddrResult = 2'd3;

  logic [15:0]     cfg1_q, cfg1_d;
  logic [15:0]     cfg2_q, cfg2_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            nempty_q, nempty_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full;
  logic flush, clr_ovf, pop, push, ovf_evt;

  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LvlFull);
    flush      = bus_we_in && (bus_addr_in == AddrStatus) && bus_wdata_in[1];
    clr_ovf    = bus_we_in && (bus_addr_in == AddrStatus) && bus_wdata_in[0];
    pop        = bus_re_in && (bus_addr_in == AddrResult) && !fifo_empty;
    // A pop on a full FIFO frees the slot the coincident push needs.
    push       = conv_finished_in && !flush && (!fifo_full || pop);
    ovf_evt    = conv_finished_in && !flush && fifo_full && !pop;
  end

  always_comb begin
    cfg1_d   = cfg1_q;
    cfg2_d   = cfg2_q;
    if (bus_we_in && (bus_addr_in == AddrCfg1)) cfg1_d = bus_wdata_in;
    if (bus_we_in && (bus_addr_in == AddrCfg2)) cfg2_d = bus_wdata_in;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      level_d  = level_q + LvlW'(push) - LvlW'(pop);
    end
    nempty_d = (level_d != '0);

    // Set beats clear when both land in the same cycle.
    ovf_d = ovf_evt ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    cnt_d = cnt_q + 8'(conv_finished_in);
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = bus_re_in;
    if (bus_re_in) begin
      unique case (bus_addr_in)
        AddrCfg1:   rdata_d = cfg1_q;
        AddrCfg2:   rdata_d = cfg2_q;
        AddrStatus: rdata_d = {cnt_q, ovf_q, 7'(level_q)};
        AddrResult: rdata_d = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
        default:    rdata_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg1_q   <= CONFIG1_RESET;
      cfg2_q   <= CONFIG2_RESET;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= 8'h00;
      rdata_q  <= 16'h0000;
      rvalid_q <= 1'b0;
      nempty_q <= 1'b0;
    end else begin
      cfg1_q   <= cfg1_d;
      cfg2_q   <= cfg2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      nempty_q <= nempty_d;
    end
  end

  // Storage needs no reset; level and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= result_in;
  end

  assign config_1_out    = cfg1_q;
  assign config_2_out    = cfg2_q;
  assign bus_rdata_out   = rdata_q;
  assign bus_rvalid_out  = rvalid_q;
  assign fifo_nempty_out = nempty_q;

endmodule

// File: doc/adc_host_bridge.md
Name: adc_host_bridge

Overview:
- Host-side counterpart of the ADC digital core's configuration/result interface.
- Holds the two 16-bit configuration words that drive config_1/config_2 of the ADC core.
- Captures each result_out word on the conv_finished strobe into a small FIFO.
- Exposes configuration, status and result data to a host over a simple single-cycle register bus with registered read data.

Parameters:
FIFO_DEPTH, 8, result FIFO entries; power of two, 2..64
CONFIG1_RESET, 16'h0000, reset value of config_1_out
CONFIG2_RESET, 16'h0000, reset value of config_2_out

Ports:
clk  in  1  digital clock, same clock as the ADC digital core
rst_n  in  1  asynchronous active-low reset
config_1_out  out  16  to ADC core config_1_in
config_2_out  out  16  to ADC core config_2_in
result_in  in  16  from ADC core result_out
conv_finished_in  in  1  from ADC core conv_finished_out; 1-cycle strobe, result_in valid in same cycle
bus_addr_in  in  2  register address
bus_wdata_in  in  16  write data
bus_we_in  in  1  write strobe, 1 cycle per access
bus_re_in  in  1  read strobe, 1 cycle per access
bus_rdata_out  out  16  read data, valid when bus_rvalid_out=1
bus_rvalid_out  out  1  read data valid, 1 cycle
fifo_nempty_out  out  1  FIFO holds at least one result (host interrupt)

Behaviour:
- Reset: config_1_out=CONFIG1_RESET, config_2_out=CONFIG2_RESET. FIFO empty. Overflow flag=0. Sample counter=0. bus_rdata_out=0, bus_rvalid_out=0, fifo_nempty_out=0.
- Register map:
  - 0: CONFIG1, RW.
  - 1: CONFIG2, RW.
  - 2: STATUS. Read: [6:0]=FIFO level (0..FIFO_DEPTH), [7]=overflow, [15:8]=sample counter[7:0]. Write: bit0=1 clears overflow; bit1=1 flushes FIFO; other bits ignored.
  - 3: RESULT. Read only; writes ignored.
- Writes: take effect at the clock edge where bus_we_in=1. New config value is visible on the outputs on the next cycle.
- Reads: bus_re_in=1 in cycle N gives bus_rvalid_out=1 and bus_rdata_out in cycle N+1. bus_rdata_out holds its value until the next read. bus_rvalid_out is high for exactly one cycle per read.
- bus_we_in and bus_re_in both high in the same cycle: write executes, read executes and returns the pre-write value. For STATUS, the read returns the pre-clear/pre-flush status.
- RESULT read:
  - FIFO not empty: returns head entry and pops it on the same edge (level decrements).
  - FIFO empty: returns 16'h0000, no pop, no flag change.
- Push: conv_finished_in=1 writes result_in to the tail. Sample counter increments, wrapping at 2^8.
- Simultaneous push and RESULT pop:
  - Both happen in the same cycle and the level is unchanged.
  - Applies when full, so no overflow in that case.
  - When empty, the pop does not occur; the read returns 0 and the push is stored.
- Full (level=FIFO_DEPTH) with push and no pop: the new sample is dropped, overflow set to 1 (sticky), sample counter still increments.
- Flush: level->0 and pointers reset. A push in the same cycle is discarded (flush wins). A same-cycle RESULT read returns the pre-flush head.
- Overflow clear and a new overflow event in the same cycle: the set wins, flag stays 1.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. Level is held as log2(FIFO_DEPTH)+1 bits.
- fifo_nempty_out = (level != 0), registered state with no combinational path from the bus.
- Asynchronous reset mid-operation: all state returns to reset values immediately; FIFO contents are don't-care.
- No combinational path from any input to any output.

Test Plan:
- Reset, then read addr 0/1/2 -> rdata 0x0000 each, rvalid one cycle after each re; config outputs equal the reset parameters.
- Write 0x002B to addr 0 and 0xA5A5 to addr 1 -> config_1_out=0x002B and config_2_out=0xA5A5 one cycle later; read back matches.
- Strobe 3 results (0x0123, 0x0456, 0x0789) -> STATUS level=3, counter=3. Three RESULT reads return them in order; a fourth read returns 0x0000; fifo_nempty_out falls after the third pop.
- Push 9 results with FIFO_DEPTH=8 -> level=8, overflow=1, counter=9; first 8 values read back, the 9th is lost. Write STATUS 0x0001 -> overflow=0.
- With FIFO full, conv_finished_in coincident with a RESULT read -> level stays 8, overflow stays 0, oldest entry returned, new value appended at tail.
- Write STATUS 0x0002 in the same cycle as conv_finished_in -> level=0, fifo_nempty_out=0 next cycle, counter incremented. Assert rst_n low mid-burst -> all outputs return to reset values asynchronously.
